// File: rtl/dec_serializer_mc.sv
// Multi-channel frame serializer: captures N_CH words on each valid_strobe rising edge into a
// holding buffer and shifts them out with a divided bit clock and a frame-sync line.
module dec_serializer_mc #(
    parameter int unsigned DATA_W      = 22,
    parameter int unsigned N_CH        = 2,
    parameter int unsigned DIV_W       = 4,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   valid_strobe,
    input  logic [N_CH*DATA_W-1:0] data_i,
    input  logic                   msb_first,
    input  logic [DIV_W-1:0]       clk_div,
    input  logic                   ovr_clr,
    output logic                   sclk_o,
    output logic                   data_o,
    output logic                   frame_sync,
    output logic                   overrun
);

    localparam int unsigned Total = N_CH * DATA_W;
    localparam int unsigned CntW  = $clog2(Total);
    localparam int unsigned ChW   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned WbW   = $clog2(DATA_W);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [Total-1:0]       hold_q, hold_d;
    logic [Total-1:0]       shift_q, shift_d;
    logic                   hold_full_q, hold_full_d;
    logic                   msb_q, msb_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DIV_W-1:0]       ph_q, ph_d;
    logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [ChW-1:0]         ch_q, ch_d;
    logic [WbW-1:0]         wb_q, wb_d;
    logic                   ovr_q, ovr_d;

    logic             load_pulse;
    logic             consume;
    logic [DIV_W-1:0] eff_div;
    logic [WbW-1:0]   word_pos;
    logic [CntW-1:0]  bit_idx;

    assign load_pulse = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    assign eff_div    = (clk_div == '0) ? DIV_W'(1) : clk_div;

    // Channel-major bit selection; word direction follows the order latched at frame start.
    assign word_pos = msb_q ? (WbW'(DATA_W - 1) - wb_q) : wb_q;
    assign bit_idx  = CntW'(ch_q) * CntW'(DATA_W) + CntW'(word_pos);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        msb_d       = msb_q;
        div_d       = div_q;
        ph_d        = ph_q;
        bit_cnt_d   = bit_cnt_q;
        ch_d        = ch_q;
        wb_d        = wb_q;
        consume     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hold_full_q) begin
                    consume   = 1'b1;
                    shift_d   = hold_q;
                    msb_d     = msb_first;
                    div_d     = eff_div;
                    bit_cnt_d = CntW'(Total - 1);
                    ch_d      = '0;
                    wb_d      = '0;
                    ph_d      = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (ph_q == div_q) begin
                    ph_d = '0;
                    if (bit_cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        if (wb_q == WbW'(DATA_W - 1)) begin
                            wb_d = '0;
                            ch_d = ch_q + 1'b1;
                        end else begin
                            wb_d = wb_q + 1'b1;
                        end
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A capture coinciding with consumption refills the buffer without counting as a loss.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ovr_d       = ovr_q;
        if (load_pulse) begin
            hold_d      = data_i;
            hold_full_d = 1'b1;
        end else if (consume) begin
            hold_full_d = 1'b0;
        end
        if (load_pulse && hold_full_q && !consume) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= StIdle;
            sync_q      <= '0;
            hold_q      <= '0;
            shift_q     <= '0;
            hold_full_q <= 1'b0;
            msb_q       <= 1'b0;
            div_q       <= '0;
            ph_q        <= '0;
            bit_cnt_q   <= '0;
            ch_q        <= '0;
            wb_q        <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], valid_strobe};
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            hold_full_q <= hold_full_d;
            msb_q       <= msb_d;
            div_q       <= div_d;
            ph_q        <= ph_d;
            bit_cnt_q   <= bit_cnt_d;
            ch_q        <= ch_d;
            wb_q        <= wb_d;
            ovr_q       <= ovr_d;
        end
    end

    assign frame_sync = (state_q == StShift);
    assign sclk_o     = frame_sync & (ph_q > (div_q >> 1));
    assign data_o     = frame_sync & shift_q[bit_idx];
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_dec_serializer_mc.sv
// Bench for dec_serializer_mc: default 2x22 instance plus a 4x16 instance, checked against a
// bit-list model of each frame built from channel words, bit order and divider.
module tb_dec_serializer_mc;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        strobe_s = 1'b0;
    logic        strobe_b = 1'b0;
    logic [43:0] data_s = '0;
    logic [63:0] data_b = '0;
    logic        msb_first = 1'b1;
    logic [3:0]  clk_div = 4'd1;
    logic        ovr_clr = 1'b0;
    logic        sclk_s, dout_s, fs_s, ovr_s;
    logic        sclk_b, dout_b, fs_b, ovr_b;

    int n_assert = 0;
    int n_fail   = 0;
    logic exp_bits [0:63];
    int   exp_len = 0;

    always #5 clk = ~clk;

    dec_serializer_mc u_dut_s (
        .clk(clk), .rst_b(rst_b), .valid_strobe(strobe_s), .data_i(data_s),
        .msb_first(msb_first), .clk_div(clk_div), .ovr_clr(ovr_clr),
        .sclk_o(sclk_s), .data_o(dout_s), .frame_sync(fs_s), .overrun(ovr_s)
    );

    dec_serializer_mc #(.DATA_W(16), .N_CH(4), .DIV_W(4), .SYNC_STAGES(3)) u_dut_b (
        .clk(clk), .rst_b(rst_b), .valid_strobe(strobe_b), .data_i(data_b),
        .msb_first(msb_first), .clk_div(clk_div), .ovr_clr(ovr_clr),
        .sclk_o(sclk_b), .data_o(dout_b), .frame_sync(fs_b), .overrun(ovr_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame = channel 0 first, each word walked MSB->LSB or LSB->MSB.
    task automatic build_exp(input logic [63:0] flat, input int nch, input int w, input bit msb);
        exp_len = 0;
        for (int k = 0; k < nch; k++) begin
            for (int i = 0; i < w; i++) begin
                exp_bits[exp_len] = flat[k*w + (msb ? (w - 1 - i) : i)];
                exp_len++;
            end
        end
    endtask

    task automatic inject_s(input int dly, input logic [43:0] d);
        repeat (dly) tick();
        data_s   = d;
        strobe_s = 1'b1;
        repeat (3) tick();
        strobe_s = 1'b0;
    endtask

    task automatic inject_b(input int dly, input logic [63:0] d);
        repeat (dly) tick();
        data_b   = d;
        strobe_b = 1'b1;
        repeat (3) tick();
        strobe_b = 1'b0;
    endtask

    task automatic wait_frame(input bit big, input int limit, input string tag, output int n);
        n = 0;
        while (((big ? fs_b : fs_s) !== 1'b1) && (n < limit)) begin
            tick();
            n++;
        end
        check({tag, "_start"}, 64'(big ? fs_b : fs_s), 64'd1);
    endtask

    // Called on the first sample with frame_sync high; checks every clk cycle of the frame.
    task automatic check_frame(input bit big, input int eff, input string tag);
        int e_fs = 0;
        int e_sc = 0;
        int e_d  = 0;
        int per  = eff + 1;
        for (int c = 0; c < exp_len * per; c++) begin
            int  ph = c % per;
            bit  sc_exp = (ph > eff / 2);
            if ((big ? fs_b : fs_s) !== 1'b1) e_fs++;
            if ((big ? sclk_b : sclk_s) !== sc_exp) e_sc++;
            if ((big ? dout_b : dout_s) !== exp_bits[c / per]) e_d++;
            tick();
        end
        check({tag, "_fs_errs"}, 64'(e_fs), 64'd0);
        check({tag, "_sclk_errs"}, 64'(e_sc), 64'd0);
        check({tag, "_data_errs"}, 64'(e_d), 64'd0);
        check({tag, "_gap"}, 64'(big ? fs_b : fs_s), 64'd0);
    endtask

    initial begin
        int          n;
        int          busy;
        int          eff;
        logic [63:0] r;
        logic [43:0] da, db, dc, dd, de;

        repeat (3) tick();
        check("rst_sclk", 64'(sclk_s), 64'd0);
        check("rst_data", 64'(dout_s), 64'd0);
        check("rst_fs", 64'(fs_s), 64'd0);
        check("rst_ovr", 64'(ovr_s), 64'd0);
        check("rst_fs_big", 64'(fs_b), 64'd0);
        rst_b = 1'b1;
        repeat (2) tick();

        // Directed frame: latency, MSB-first pattern, exactly one frame.
        msb_first = 1'b1;
        clk_div   = 4'd1;
        da        = {22'h000001, 22'h3FFFFE};
        fork
            inject_s(0, da);
            begin
                wait_frame(1'b0, 50, "t1", n);
                check("t1_latency", 64'(n), 64'd4);
                build_exp({20'd0, da}, 2, 22, 1'b1);
                check("t1_bits_lo", {63'd0, exp_bits[21]}, 64'd0);
                check_frame(1'b0, 1, "t1");
            end
        join
        busy = 0;
        repeat (60) begin
            if (fs_s !== 1'b0) busy++;
            tick();
        end
        check("t1_one_frame", 64'(busy), 64'd0);

        // LSB-first, then divider corner cases.
        msb_first = 1'b0;
        fork
            inject_s(0, da);
            begin
                wait_frame(1'b0, 50, "t2", n);
                build_exp({20'd0, da}, 2, 22, 1'b0);
                check_frame(1'b0, 1, "t2");
            end
        join
        msb_first = 1'b1;
        for (int k = 0; k < 2; k++) begin
            clk_div = (k == 0) ? 4'd0 : 4'd4;
            eff     = (k == 0) ? 1 : 4;
            r       = {$urandom(), $urandom()};
            db      = r[43:0];
            fork
                inject_s(0, db);
                begin
                    wait_frame(1'b0, 50, "t3", n);
                    build_exp({20'd0, db}, 2, 22, 1'b1);
                    check_frame(1'b0, eff, (k == 0) ? "div0" : "div4");
                end
            join
        end

        // Double buffering, including refill on the same edge the buffer is consumed.
        clk_div = 4'd1;
        r  = {$urandom(), $urandom()}; da = r[43:0];
        r  = {$urandom(), $urandom()}; db = r[43:0];
        r  = {$urandom(), $urandom()}; dc = r[43:0];
        fork
            inject_s(0, da);
            inject_s(14, db);
            inject_s(90, dc);
            begin
                wait_frame(1'b0, 50, "dbA", n);
                build_exp({20'd0, da}, 2, 22, 1'b1);
                check_frame(1'b0, 1, "dbA");
                wait_frame(1'b0, 50, "dbB", n);
                check("dbB_gap_len", 64'(n), 64'd1);
                build_exp({20'd0, db}, 2, 22, 1'b1);
                check_frame(1'b0, 1, "dbB");
                wait_frame(1'b0, 50, "dbC", n);
                check("dbC_gap_len", 64'(n), 64'd1);
                build_exp({20'd0, dc}, 2, 22, 1'b1);
                check_frame(1'b0, 1, "dbC");
                check("db_no_ovr", 64'(ovr_s), 64'd0);
            end
        join

        // Overrun: newest wins; then set beats a simultaneous clear.
        r  = {$urandom(), $urandom()}; da = r[43:0];
        r  = {$urandom(), $urandom()}; db = r[43:0];
        r  = {$urandom(), $urandom()}; dc = r[43:0];
        fork
            inject_s(0, da);
            inject_s(14, db);
            inject_s(40, dc);
            begin
                wait_frame(1'b0, 50, "ovA", n);
                build_exp({20'd0, da}, 2, 22, 1'b1);
                check_frame(1'b0, 1, "ovA");
                check("ov_set", 64'(ovr_s), 64'd1);
                wait_frame(1'b0, 50, "ovC", n);
                check("ovC_gap_len", 64'(n), 64'd1);
                build_exp({20'd0, dc}, 2, 22, 1'b1);
                check_frame(1'b0, 1, "ovC");
                check("ov_sticky", 64'(ovr_s), 64'd1);
            end
        join
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ov_clr", 64'(ovr_s), 64'd0);
        r  = {$urandom(), $urandom()}; dd = r[43:0];
        r  = {$urandom(), $urandom()}; db = r[43:0];
        r  = {$urandom(), $urandom()}; de = r[43:0];
        fork
            inject_s(0, dd);
            inject_s(14, db);
            inject_s(40, de);
            begin
                repeat (42) tick();
                ovr_clr = 1'b1;
                tick();
                ovr_clr = 1'b0;
            end
            begin
                wait_frame(1'b0, 50, "ovD", n);
                build_exp({20'd0, dd}, 2, 22, 1'b1);
                check_frame(1'b0, 1, "ovD");
                check("ov_set_beats_clr", 64'(ovr_s), 64'd1);
                wait_frame(1'b0, 50, "ovE", n);
                build_exp({20'd0, de}, 2, 22, 1'b1);
                check_frame(1'b0, 1, "ovE");
            end
        join

        // Config changes mid-frame must not affect the frame in flight.
        msb_first = 1'b1;
        clk_div   = 4'd2;
        r  = {$urandom(), $urandom()}; da = r[43:0];
        fork
            inject_s(0, da);
            begin
                wait_frame(1'b0, 50, "cfg", n);
                build_exp({20'd0, da}, 2, 22, 1'b1);
                fork
                    begin
                        repeat (7) tick();
                        msb_first = 1'b0;
                        clk_div   = 4'd5;
                    end
                    check_frame(1'b0, 2, "cfg");
                join
            end
        join

        // Randomized frames.
        for (int it = 0; it < 5; it++) begin
            r         = {$urandom(), $urandom()};
            da        = r[43:0];
            clk_div   = 4'($urandom_range(0, 5));
            msb_first = 1'($urandom_range(0, 1));
            eff       = (clk_div == 4'd0) ? 1 : int'(clk_div);
            fork
                inject_s(0, da);
                begin
                    wait_frame(1'b0, 50, "rnd", n);
                    check("rnd_latency", 64'(n), 64'd4);
                    build_exp({20'd0, da}, 2, 22, msb_first);
                    check_frame(1'b0, eff, "rnd");
                end
            join
        end

        // 4x16 instance.
        msb_first = 1'b1;
        clk_div   = 4'd1;
        fork
            inject_b(0, {16'h0001, 16'hFFFF, 16'h0F0F, 16'hA5A5});
            begin
                wait_frame(1'b1, 50, "big", n);
                build_exp({16'h0001, 16'hFFFF, 16'h0F0F, 16'hA5A5}, 4, 16, 1'b1);
                check_frame(1'b1, 1, "big");
            end
        join

        // Reset at bit 10 of a frame; overrun is still set from earlier.
        check("pre_rst_ovr", 64'(ovr_s), 64'd1);
        r  = {$urandom(), $urandom()};
        da = r[43:0] | 44'h1;
        fork
            inject_s(0, da);
            begin
                wait_frame(1'b0, 50, "mrst", n);
                repeat (20) tick();
            end
        join
        check("mrst_pre_fs", 64'(fs_s), 64'd1);
        rst_b = 1'b0;
        #1;
        check("mrst_sclk", 64'(sclk_s), 64'd0);
        check("mrst_data", 64'(dout_s), 64'd0);
        check("mrst_fs", 64'(fs_s), 64'd0);
        check("mrst_ovr", 64'(ovr_s), 64'd0);
        repeat (3) tick();
        rst_b = 1'b1;
        busy  = 0;
        repeat (100) begin
            if ((fs_s !== 1'b0) || (sclk_s !== 1'b0) || (dout_s !== 1'b0) || (ovr_s !== 1'b0))
                busy++;
            tick();
        end
        check("post_rst_quiet", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
